// File: rtl/tcm_boot_roi_ctrl.sv
// Boot/profiling sequencer: streams a program into instruction TCM, pulses the core reset,
// then counts cycles and retirements between a start PC and an end PC.
// Optional run-phase timeout is enabled by defining TCM_BOOT_TIMEOUT_EN.
module tcm_boot_roi_ctrl #(
  parameter int MAX_WORDS      = 1024,
  parameter int RST_CYCLES     = 2,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             word_valid_i,
  output logic             word_ready_o,
  input  logic [31:0]      word_data_i,
  input  logic             word_last_i,
  output logic [3:0]       inst_we_o,
  output logic [31:0]      inst_addr_o,
  output logic [31:0]      inst_data_o,
  output logic             rst_cpu_o,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      retired_cnt_i,
  input  logic [31:0]      roi_start_pc_i,
  input  logic [31:0]      roi_end_pc_i,
  output logic             busy_o,
  output logic             roi_active_o,
  output logic             done_o,
  output logic             load_err_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] roi_cycles_o,
  output logic [CNT_W-1:0] roi_retired_o
);

  localparam int MAX_BYTES = MAX_WORDS * 4;
  localparam int PTR_W     = $clog2(MAX_BYTES) + 1;
  localparam int RC_W      = $clog2(RST_CYCLES + 1);

  // S_FLUSH is the write cycle of the last word, before the core reset window starts.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_FLUSH   = 3'd2,
    S_RST_CPU = 3'd3,
    S_RUN     = 3'd4,
    S_ROI     = 3'd5,
    S_DONE    = 3'd6
  } state_e;

  state_e           state_r;
  state_e           state_n;
  logic [PTR_W-1:0] ptr_r;
  logic [RC_W-1:0]  rst_cnt_r;
  logic [31:0]      prev_r;
  logic [CNT_W-1:0] cyc_r;
  logic [CNT_W-1:0] ret_r;
  logic [3:0]       we_r;
  logic [31:0]      addr_r;
  logic [31:0]      data_r;
  logic             rst_cpu_r;
  logic             ready_r;
  logic             busy_r;
  logic             roi_act_r;
  logic             done_r;
  logic             load_err_r;
  logic             timeout_r;

  logic             accept_s;
  logic             in_range_s;
  logic             start_s;
  logic             timeout_hit_s;

  assign accept_s   = (state_r == S_LOAD) && word_valid_i;
  assign in_range_s = (ptr_r < PTR_W'(MAX_BYTES));
  assign start_s    = start_i && ((state_r == S_IDLE) || (state_r == S_DONE));

`ifdef TCM_BOOT_TIMEOUT_EN
  localparam int RUN_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [RUN_W-1:0] run_cnt_r;

  // Run-phase cycle counter; cleared during the reset window so it starts at 0 in RUN.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      run_cnt_r <= '0;
    end else if (state_r == S_RST_CPU) begin
      run_cnt_r <= '0;
    end else if ((state_r == S_RUN) || (state_r == S_ROI)) begin
      run_cnt_r <= run_cnt_r + RUN_W'(1);
    end else begin
      run_cnt_r <= run_cnt_r;
    end
  end

  assign timeout_hit_s = ((state_r == S_RUN) || (state_r == S_ROI)) &&
                         (run_cnt_r == RUN_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state logic.
  always_comb begin
    state_n = state_r;
    case (state_r)
      S_IDLE: begin
        if (start_i) state_n = S_LOAD;
        else         state_n = S_IDLE;
      end
      S_LOAD: begin
        if (accept_s && word_last_i) state_n = S_FLUSH;
        else                         state_n = S_LOAD;
      end
      S_FLUSH: begin
        state_n = S_RST_CPU;
      end
      S_RST_CPU: begin
        if (rst_cnt_r == RC_W'(RST_CYCLES - 1)) state_n = S_RUN;
        else                                    state_n = S_RST_CPU;
      end
      S_RUN: begin
        if (timeout_hit_s)              state_n = S_DONE;
        else if (pc_i == roi_start_pc_i) state_n = S_ROI;
        else                            state_n = S_RUN;
      end
      S_ROI: begin
        if (timeout_hit_s)             state_n = S_DONE;
        else if (pc_i == roi_end_pc_i) state_n = S_DONE;
        else                           state_n = S_ROI;
      end
      S_DONE: begin
        if (start_i) state_n = S_LOAD;
        else         state_n = S_DONE;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // Datapath: TCM write port, load pointer, reset window, ROI counters and status flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_r      <= '0;
      rst_cnt_r  <= '0;
      prev_r     <= 32'h0;
      cyc_r      <= '0;
      ret_r      <= '0;
      we_r       <= 4'h0;
      addr_r     <= 32'h0;
      data_r     <= 32'h0;
      rst_cpu_r  <= 1'b1;
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      roi_act_r  <= 1'b0;
      done_r     <= 1'b0;
      load_err_r <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      ready_r   <= (state_n == S_LOAD);
      busy_r    <= (state_n != S_IDLE) && (state_n != S_DONE);
      roi_act_r <= (state_n == S_ROI);
      done_r    <= (state_n == S_DONE);
      rst_cpu_r <= (state_n inside {S_IDLE, S_LOAD, S_FLUSH, S_RST_CPU});
      prev_r    <= retired_cnt_i;
      we_r      <= 4'h0;

      if (start_s) begin
        ptr_r      <= '0;
        load_err_r <= 1'b0;
        timeout_r  <= 1'b0;
      end else if (accept_s) begin
        addr_r <= 32'(ptr_r);
        data_r <= word_data_i;
        // Zero words are skipped on the bus but still consume an address slot.
        if (in_range_s) begin
          ptr_r <= ptr_r + PTR_W'(4);
          if (word_data_i != 32'h0) we_r <= 4'hf;
        end else begin
          load_err_r <= 1'b1;
        end
      end

      if (state_r == S_RST_CPU) rst_cnt_r <= rst_cnt_r + RC_W'(1);
      else                      rst_cnt_r <= '0;

      // The start-PC cycle is the first counted cycle; its retirement is not counted.
      if (start_s) begin
        cyc_r <= '0;
        ret_r <= '0;
      end else if ((state_r == S_RUN) && (state_n == S_ROI)) begin
        cyc_r <= CNT_W'(1);
        ret_r <= '0;
      end else if ((state_r == S_ROI) && !timeout_hit_s) begin
        if (cyc_r != {CNT_W{1'b1}}) cyc_r <= cyc_r + CNT_W'(1);
        if ((retired_cnt_i != prev_r) && (ret_r != {CNT_W{1'b1}})) ret_r <= ret_r + CNT_W'(1);
      end

      if (timeout_hit_s) timeout_r <= 1'b1;
    end
  end

  assign word_ready_o  = ready_r;
  assign inst_we_o     = we_r;
  assign inst_addr_o   = addr_r;
  assign inst_data_o   = data_r;
  assign rst_cpu_o     = rst_cpu_r;
  assign busy_o        = busy_r;
  assign roi_active_o  = roi_act_r;
  assign done_o        = done_r;
  assign load_err_o    = load_err_r;
  assign timeout_o     = timeout_r;
  assign roi_cycles_o  = cyc_r;
  assign roi_retired_o = ret_r;

endmodule

// File: tb/tb_tcm_boot_roi_ctrl.sv
// Self-checking bench for tcm_boot_roi_ctrl: directed load/ROI vectors, reset corners,
// timeout behaviour and randomized runs against a scan-based reference model.
module tb_tcm_boot_roi_ctrl;
  localparam int MW = 16;
  localparam int RC = 2;
  localparam int TO = 50;
  localparam logic [31:0] IDLE_PC = 32'hFFFF_FFF0;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic        word_valid_i = 1'b0;
  logic        word_ready_o;
  logic [31:0] word_data_i = 32'h0;
  logic        word_last_i = 1'b0;
  logic [3:0]  inst_we_o;
  logic [31:0] inst_addr_o;
  logic [31:0] inst_data_o;
  logic        rst_cpu_o;
  logic [31:0] pc_i = IDLE_PC;
  logic [31:0] retired_cnt_i = 32'h0;
  logic [31:0] roi_start_pc_i = 32'h0;
  logic [31:0] roi_end_pc_i = 32'h0;
  logic        busy_o, roi_active_o, done_o, load_err_o, timeout_o;
  logic [31:0] roi_cycles_o, roi_retired_o;

  // Narrow-counter instance used to observe saturation.
  logic        d2_ready, d2_rst_cpu, d2_busy, d2_roi_active, d2_done, d2_load_err, d2_timeout;
  logic [3:0]  d2_we;
  logic [31:0] d2_addr, d2_data;
  logic [2:0]  d2_cycles, d2_retired;

  always #5 clk = ~clk;

  tcm_boot_roi_ctrl #(.MAX_WORDS(MW), .RST_CYCLES(RC), .CNT_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .word_valid_i(word_valid_i),
    .word_ready_o(word_ready_o), .word_data_i(word_data_i), .word_last_i(word_last_i),
    .inst_we_o(inst_we_o), .inst_addr_o(inst_addr_o), .inst_data_o(inst_data_o),
    .rst_cpu_o(rst_cpu_o), .pc_i(pc_i), .retired_cnt_i(retired_cnt_i),
    .roi_start_pc_i(roi_start_pc_i), .roi_end_pc_i(roi_end_pc_i), .busy_o(busy_o),
    .roi_active_o(roi_active_o), .done_o(done_o), .load_err_o(load_err_o),
    .timeout_o(timeout_o), .roi_cycles_o(roi_cycles_o), .roi_retired_o(roi_retired_o));

  tcm_boot_roi_ctrl #(.MAX_WORDS(MW), .RST_CYCLES(RC), .CNT_W(3), .TIMEOUT_CYCLES(TO)) dut2 (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .word_valid_i(word_valid_i),
    .word_ready_o(d2_ready), .word_data_i(word_data_i), .word_last_i(word_last_i),
    .inst_we_o(d2_we), .inst_addr_o(d2_addr), .inst_data_o(d2_data),
    .rst_cpu_o(d2_rst_cpu), .pc_i(pc_i), .retired_cnt_i(retired_cnt_i),
    .roi_start_pc_i(roi_start_pc_i), .roi_end_pc_i(roi_end_pc_i), .busy_o(d2_busy),
    .roi_active_o(d2_roi_active), .done_o(d2_done), .load_err_o(d2_load_err),
    .timeout_o(d2_timeout), .roi_cycles_o(d2_cycles), .roi_retired_o(d2_retired));

  typedef struct { logic [3:0] we; logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct {
    logic [31:0] start_pc; logic [31:0] end_pc; int n_mid; logic [15:0] inc_mask;
    bit end_inc; int exp_cycles; int exp_retired;
  } roi_vec_t;

  wr_t         wr_q[$];
  logic [31:0] prog_q[$];
  logic [31:0] pc_q[$];
  logic [31:0] ret_q[$];
  logic [31:0] w4[4];
  roi_vec_t    vecs[4];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          ok;

  // Write-port monitor.
  always @(negedge clk) begin
    if (inst_we_o != 4'h0) wr_q.push_back('{inst_we_o, inst_addr_o, inst_data_o});
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic pulse_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  // Start a load of prog_q, then wait (bounded) for the core reset to drop.
  task automatic load_prog(input bit stalls, output bit reached);
    int guard;
    wr_q.delete();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < prog_q.size(); i++) begin
      if (stalls) begin
        repeat ($urandom_range(0, 2)) begin
          word_valid_i = 1'b0;
          word_data_i  = $urandom;
          tick();
        end
      end
      word_valid_i = 1'b1;
      word_data_i  = prog_q[i];
      word_last_i  = (i == prog_q.size() - 1);
      tick();
    end
    word_valid_i = 1'b0;
    word_last_i  = 1'b0;
    guard = 0;
    while (rst_cpu_o && guard < 20) begin
      tick();
      guard++;
    end
    reached = !rst_cpu_o;
    chk("reach_run", reached, 1'b1);
  endtask

  // Expected writes: word i lands at 4*i when nonzero and inside the TCM.
  task automatic check_writes();
    wr_t exp_q[$];
    for (int i = 0; i < prog_q.size(); i++) begin
      if (i < MW && prog_q[i] != 32'h0) exp_q.push_back('{4'hf, 32'(i * 4), prog_q[i]});
    end
    chk("wr_count", wr_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < wr_q.size(); i++) begin
      chk("wr_rec", {wr_q[i].we, wr_q[i].addr, wr_q[i].data},
          {exp_q[i].we, exp_q[i].addr, exp_q[i].data});
    end
  endtask

  task automatic drive_seq();
    for (int k = 0; k < pc_q.size(); k++) begin
      pc_i          = pc_q[k];
      retired_cnt_i = ret_q[k];
      tick();
    end
    pc_i = IDLE_PC;
  endtask

  // ROI = first start-PC cycle through next end-PC cycle, inclusive; retirements are
  // value changes relative to the previous cycle, counted after the start cycle.
  task automatic roi_model(output int cyc, output int ret);
    int s, e;
    s = -1;
    e = -1;
    for (int k = 0; k < pc_q.size(); k++) begin
      if (s < 0) begin
        if (pc_q[k] == roi_start_pc_i) s = k;
      end else if (e < 0 && pc_q[k] == roi_end_pc_i) begin
        e = k;
      end
    end
    cyc = e - s + 1;
    ret = 0;
    for (int k = s + 1; k <= e; k++) if (ret_q[k] != ret_q[k-1]) ret++;
  endtask

  initial begin
    w4 = '{32'h0000_0013, 32'h0000_0000, 32'h0050_0093, 32'hfff0_0113};
    vecs[0] = '{32'h170, 32'h264, 10, 16'h00DB, 1'b1, 12, 7};
    vecs[1] = '{32'h200, 32'h200, 3, 16'h0007, 1'b0, 5, 3};
    vecs[2] = '{32'h100, 32'h104, 0, 16'h0000, 1'b1, 2, 1};
    vecs[3] = '{32'h040, 32'h080, 5, 16'h0000, 1'b0, 7, 0};

    // Reset state.
    rst_i = 1'b1;
    repeat (2) tick();
    chk("rst_rst_cpu", rst_cpu_o, 1'b1);
    chk("rst_flags", {busy_o, roi_active_o, done_o, load_err_o, timeout_o, word_ready_o}, 6'h0);
    chk("rst_wport", {inst_we_o, inst_addr_o, inst_data_o}, 68'h0);
    chk("rst_counts", {roi_cycles_o, roi_retired_o}, 64'h0);
    rst_i = 1'b0;
    tick();

    // Four-word program with a zero word.
    wr_q.delete();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("h1_ready", word_ready_o, 1'b1);
    chk("h1_busy", busy_o, 1'b1);
    for (int i = 0; i < 4; i++) begin
      word_valid_i = 1'b1;
      word_data_i  = w4[i];
      word_last_i  = (i == 3);
      tick();
      chk("h1_we", inst_we_o, (w4[i] != 32'h0) ? 4'hf : 4'h0);
      if (w4[i] != 32'h0) chk("h1_addr_data", {inst_addr_o, inst_data_o}, {32'(i * 4), w4[i]});
    end
    word_valid_i = 1'b0;
    word_last_i  = 1'b0;
    chk("h1_ready_off", word_ready_o, 1'b0);
    tick();
    chk("h1_rst_cpu_1", {rst_cpu_o, busy_o, inst_we_o}, {1'b1, 1'b1, 4'h0});
    tick();
    chk("h1_rst_cpu_2", rst_cpu_o, 1'b1);
    tick();
    chk("h1_rst_cpu_low", {rst_cpu_o, busy_o}, {1'b0, 1'b1});
    prog_q = '{w4[0], w4[1], w4[2], w4[3]};
    check_writes();

    // start_i in RUN is ignored.
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("start_ignored", {word_ready_o, busy_o, rst_cpu_o}, {1'b0, 1'b1, 1'b0});

    // Overflow: MW+2 words.
    pulse_reset();
    prog_q.delete();
    for (int i = 0; i < MW + 2; i++) prog_q.push_back(32'h1000 + 32'(i));
    wr_q.delete();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < MW + 2; i++) begin
      word_valid_i = 1'b1;
      word_data_i  = prog_q[i];
      word_last_i  = (i == MW + 1);
      tick();
      if (i == MW - 1) chk("ovf_last_fit", {load_err_o, inst_we_o, inst_addr_o}, {1'b0, 4'hf, 32'(MW * 4 - 4)});
      if (i == MW)     chk("ovf_err_set", {load_err_o, inst_we_o}, {1'b1, 4'h0});
      if (i == MW + 1) chk("ovf_final_drop", {load_err_o, inst_we_o}, {1'b1, 4'h0});
    end
    word_valid_i = 1'b0;
    word_last_i  = 1'b0;
    begin
      int guard;
      guard = 0;
      while (rst_cpu_o && guard < 20) begin
        tick();
        guard++;
      end
      chk("ovf_reach_run", rst_cpu_o, 1'b0);
    end
    check_writes();

    // Directed ROI vectors.
    for (int v = 0; v < 4; v++) begin
      logic [31:0] r;
      pulse_reset();
      roi_start_pc_i = vecs[v].start_pc;
      roi_end_pc_i   = vecs[v].end_pc;
      prog_q = '{32'h0000_0013, 32'h0050_0093};
      load_prog(1'b0, ok);
      pc_q.delete();
      ret_q.delete();
      r = retired_cnt_i;
      pc_q.push_back(vecs[v].start_pc);
      ret_q.push_back(r);
      for (int k = 0; k < vecs[v].n_mid; k++) begin
        r = r + 32'(vecs[v].inc_mask[k]);
        pc_q.push_back(32'h1000 + 32'(k * 4));
        ret_q.push_back(r);
      end
      r = r + 32'(vecs[v].end_inc);
      pc_q.push_back(vecs[v].end_pc);
      ret_q.push_back(r);
      drive_seq();
      chk("vec_flags", {done_o, roi_active_o, busy_o}, {1'b1, 1'b0, 1'b0});
      chk("vec_cycles", roi_cycles_o, 32'(vecs[v].exp_cycles));
      chk("vec_retired", roi_retired_o, 32'(vecs[v].exp_retired));
      chk("vec_sat", {d2_cycles, d2_retired},
          {(vecs[v].exp_cycles > 7) ? 3'd7 : 3'(vecs[v].exp_cycles),
           (vecs[v].exp_retired > 7) ? 3'd7 : 3'(vecs[v].exp_retired)});
      tick();
      chk("vec_hold", {done_o, roi_cycles_o}, {1'b1, 32'(vecs[v].exp_cycles)});
    end

    // Reset mid-load drops the in-flight write.
    pulse_reset();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    word_valid_i = 1'b1;
    word_data_i  = 32'hAAAA_0001;
    tick();
    word_data_i  = 32'hAAAA_0002;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    word_valid_i = 1'b0;
    chk("rst_load_drop", {inst_we_o, rst_cpu_o, busy_o, word_ready_o}, {4'h0, 1'b1, 1'b0, 1'b0});

    // Reset inside the ROI, then reload from address 0.
    roi_start_pc_i = 32'h300;
    roi_end_pc_i   = 32'h304;
    prog_q = '{32'h11, 32'h22, 32'h33};
    load_prog(1'b0, ok);
    pc_i = 32'h300;
    tick();
    pc_i = 32'h500;
    tick();
    tick();
    chk("roi_active_pre", roi_active_o, 1'b1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rst_roi", {rst_cpu_o, done_o, roi_active_o, busy_o}, {1'b1, 1'b0, 1'b0, 1'b0});
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    word_valid_i = 1'b1;
    word_data_i  = 32'h55;
    word_last_i  = 1'b1;
    tick();
    word_valid_i = 1'b0;
    word_last_i  = 1'b0;
    chk("reload_addr0", {inst_we_o, inst_addr_o, inst_data_o}, {4'hf, 32'h0, 32'h55});
    repeat (4) tick();

    // Run timeout (end PC never appears).
    pulse_reset();
    prog_q = '{32'h13};
    load_prog(1'b0, ok);
    for (int k = 1; k <= 1000; k++) begin
      pc_i = (k == 1) ? 32'h300 : 32'h500;
      tick();
`ifdef TCM_BOOT_TIMEOUT_EN
      if (k == TO - 1) chk("to_not_yet", done_o, 1'b0);
      if (k == TO) begin
        chk("to_done", {done_o, timeout_o, roi_active_o}, {1'b1, 1'b1, 1'b0});
        break;
      end
`endif
    end
`ifndef TCM_BOOT_TIMEOUT_EN
    chk("no_timeout", {done_o, timeout_o, roi_active_o}, {1'b0, 1'b0, 1'b1});
`endif
    pc_i = IDLE_PC;

    // Randomized runs, rerunning from DONE after the first.
    pulse_reset();
    for (int t = 0; t < 20; t++) begin
      int n, m, ecyc, eret;
      logic [31:0] r;
      n = (t % 5 == 4) ? MW + $urandom_range(1, 2) : $urandom_range(1, 6);
      prog_q.delete();
      for (int i = 0; i < n; i++) prog_q.push_back(($urandom_range(0, 3) == 0) ? 32'h0 : $urandom);
      roi_start_pc_i = 32'h100 + 32'($urandom_range(0, 63)) * 32'd4;
      roi_end_pc_i   = ($urandom_range(0, 3) == 0) ? roi_start_pc_i
                                                   : 32'h400 + 32'($urandom_range(0, 63)) * 32'd4;
      load_prog(1'b1, ok);
      chk("rnd_cleared", {roi_cycles_o, roi_retired_o, timeout_o}, 65'h0);
      check_writes();
      chk("rnd_load_err", load_err_o, (n > MW) ? 1'b1 : 1'b0);
      pc_q.delete();
      ret_q.delete();
      r = retired_cnt_i;
      repeat ($urandom_range(0, 3)) begin
        r = r + 32'($urandom_range(0, 2));
        pc_q.push_back(IDLE_PC);
        ret_q.push_back(r);
      end
      r = r + 32'($urandom_range(0, 1));
      pc_q.push_back(roi_start_pc_i);
      ret_q.push_back(r);
      m = $urandom_range(0, 12);
      for (int k = 0; k < m; k++) begin
        r = r + (($urandom_range(0, 2) == 0) ? 32'h0 : 32'($urandom_range(1, 3)));
        if (roi_start_pc_i != roi_end_pc_i && $urandom_range(0, 3) == 0) pc_q.push_back(roi_start_pc_i);
        else pc_q.push_back(32'h8000 + 32'($urandom_range(0, 255)) * 32'd4);
        ret_q.push_back(r);
      end
      r = r + 32'($urandom_range(0, 1));
      pc_q.push_back(roi_end_pc_i);
      ret_q.push_back(r);
      roi_model(ecyc, eret);
      drive_seq();
      chk("rnd_done", {done_o, busy_o, rst_cpu_o}, {1'b1, 1'b0, 1'b0});
      chk("rnd_cycles", roi_cycles_o, 32'(ecyc));
      chk("rnd_retired", roi_retired_o, 32'(eret));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
